// File: rtl/vec_reg_file_if.sv
// Bus bundle for vec_reg_file: bulk write, streaming load and two read ports.
// Parameters must match those of the vec_reg_file instance it connects to.
interface vec_reg_file_if #(
  parameter int unsigned BITS     = 8,
  parameter int unsigned N        = 64,
  parameter int unsigned REGS     = 16,
  parameter int unsigned LEN_BITS = 8
);
  localparam int unsigned SW = $clog2(REGS);

  logic                          wr_en;
  logic [SW-1:0]                 wr_sel;
  logic [N-1:0][BITS-1:0]        wr_data;
  logic [N-1:0]                  wr_mask;
  logic [LEN_BITS-1:0]           wr_len;
  logic                          wr_err;

  logic                          ld_valid;
  logic                          ld_ready;
  logic [SW-1:0]                 ld_sel;
  logic [BITS-1:0]               ld_data;
  logic                          ld_last;
  logic                          ld_err;

  logic                          rd_en_a;
  logic                          rd_en_b;
  logic [SW-1:0]                 rd_sel_a;
  logic [SW-1:0]                 rd_sel_b;
  logic [N-1:0][BITS-1:0]        rd_a;
  logic [N-1:0][BITS-1:0]        rd_b;
  logic [LEN_BITS-1:0]           rd_a_len;
  logic [LEN_BITS-1:0]           rd_b_len;
  logic                          rd_a_busy;
  logic                          rd_b_busy;

  modport master (
    output wr_en, wr_sel, wr_data, wr_mask, wr_len,
    output ld_valid, ld_sel, ld_data, ld_last,
    output rd_en_a, rd_en_b, rd_sel_a, rd_sel_b,
    input  wr_err, ld_ready, ld_err,
    input  rd_a, rd_b, rd_a_len, rd_b_len, rd_a_busy, rd_b_busy
  );

  modport slave (
    input  wr_en, wr_sel, wr_data, wr_mask, wr_len,
    input  ld_valid, ld_sel, ld_data, ld_last,
    input  rd_en_a, rd_en_b, rd_sel_a, rd_sel_b,
    output wr_err, ld_ready, ld_err,
    output rd_a, rd_b, rd_a_len, rd_b_len, rd_a_busy, rd_b_busy
  );
endinterface

// File: rtl/vec_reg_file.sv
// Vector register file with masked bulk write, streaming element load and two registered read ports.
// Optional feature: define VEC_RF_BYPASS_EN for write-first reads (default is read-first).
module vec_reg_file #(
  parameter int unsigned BITS     = 8,
  parameter int unsigned N        = 64,
  parameter int unsigned REGS     = 16,
  parameter int unsigned LEN_BITS = 8
) (
  input logic           clk,
  input logic           rst_n,
  vec_reg_file_if.slave bus
);
  localparam int unsigned SW = $clog2(REGS);
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  typedef logic [N-1:0][BITS-1:0] vec_t;

  vec_t                mem     [REGS];
  vec_t                mem_nxt [REGS];
  logic [LEN_BITS-1:0] len     [REGS];
  logic [LEN_BITS-1:0] len_nxt [REGS];
  logic [REGS-1:0]     busy;
  logic [REGS-1:0]     busy_nxt;

  logic [1:0]          state;
  logic [1:0]          state_nxt;
  logic [IW-1:0]       idx;
  logic [IW-1:0]       idx_nxt;
  logic [SW-1:0]       tgt;
  logic [SW-1:0]       tgt_nxt;
  logic                wr_err_nxt;
  logic                ld_err_nxt;

  logic                beat_c;
  logic                s_wr_c;
  logic [SW-1:0]       s_reg_c;
  logic [IW-1:0]       s_idx_c;
  logic                wr_ok_c;

  vec_t                src_a_c;
  vec_t                src_b_c;
  logic [LEN_BITS-1:0] src_a_len_c;
  logic [LEN_BITS-1:0] src_b_len_c;
  logic                src_a_busy_c;
  logic                src_b_busy_c;

  // Stream FSM plus next-state of the whole array (stream element, then bulk write)
  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    tgt_nxt    = tgt;
    mem_nxt    = mem;
    len_nxt    = len;
    busy_nxt   = busy;
    wr_err_nxt = 1'b0;
    ld_err_nxt = 1'b0;
    s_wr_c     = 1'b0;
    s_reg_c    = tgt;
    s_idx_c    = idx;
    wr_ok_c    = 1'b0;
    beat_c     = bus.ld_valid && bus.ld_ready;

    case (state)
      IDLE: begin
        if (beat_c) begin
          s_wr_c  = 1'b1;
          s_reg_c = bus.ld_sel;
          s_idx_c = '0;
          tgt_nxt = bus.ld_sel;
          idx_nxt = IW'(1);
          if (bus.ld_last) begin
            len_nxt[bus.ld_sel] = LEN_BITS'(1);
          end else begin
            len_nxt[bus.ld_sel]  = '0;
            busy_nxt[bus.ld_sel] = 1'b1;
            state_nxt            = LOAD;
          end
        end
      end
      LOAD: begin
        if (beat_c) begin
          s_wr_c  = 1'b1;
          idx_nxt = idx + IW'(1);
          if (bus.ld_last) begin
            len_nxt[tgt]  = LEN_BITS'(idx) + LEN_BITS'(1);
            busy_nxt[tgt] = 1'b0;
            idx_nxt       = '0;
            state_nxt     = IDLE;
          end else if (idx == IW'(N - 1)) begin
            // Overflow: keep the N elements loaded, drop the rest of the stream
            len_nxt[tgt]  = LEN_BITS'(N);
            busy_nxt[tgt] = 1'b0;
            ld_err_nxt    = 1'b1;
            idx_nxt       = '0;
            state_nxt     = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (beat_c && bus.ld_last) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (s_wr_c) begin
      mem_nxt[s_reg_c][s_idx_c] = bus.ld_data;
    end

    // Bulk write loses to a stream owning (or starting on) the same register
    wr_ok_c = !(busy[bus.wr_sel] || (s_wr_c && (s_reg_c == bus.wr_sel)));
    if (bus.wr_en) begin
      if (wr_ok_c) begin
        for (int unsigned i = 0; i < N; i++) begin
          if (bus.wr_mask[i]) begin
            mem_nxt[bus.wr_sel][i] = bus.wr_data[i];
          end
        end
        len_nxt[bus.wr_sel] = (bus.wr_len > LEN_BITS'(N)) ? LEN_BITS'(N) : bus.wr_len;
      end else begin
        wr_err_nxt = 1'b1;
      end
    end
  end

  // Read source: post-write view when bypassing, stored view otherwise
  always_comb begin
`ifdef VEC_RF_BYPASS_EN
    src_a_c      = mem_nxt[bus.rd_sel_a];
    src_b_c      = mem_nxt[bus.rd_sel_b];
    src_a_len_c  = len_nxt[bus.rd_sel_a];
    src_b_len_c  = len_nxt[bus.rd_sel_b];
    src_a_busy_c = busy_nxt[bus.rd_sel_a];
    src_b_busy_c = busy_nxt[bus.rd_sel_b];
`else
    src_a_c      = mem[bus.rd_sel_a];
    src_b_c      = mem[bus.rd_sel_b];
    src_a_len_c  = len[bus.rd_sel_a];
    src_b_len_c  = len[bus.rd_sel_b];
    src_a_busy_c = busy[bus.rd_sel_a];
    src_b_busy_c = busy[bus.rd_sel_b];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      tgt   <= '0;
      busy  <= '0;
      for (int unsigned r = 0; r < REGS; r++) begin
        mem[r] <= '0;
        len[r] <= '0;
      end
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      tgt   <= tgt_nxt;
      busy  <= busy_nxt;
      for (int unsigned r = 0; r < REGS; r++) begin
        mem[r] <= mem_nxt[r];
        len[r] <= len_nxt[r];
      end
    end
  end

  // Registered status and read outputs; disabled ports read as zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.ld_ready  <= 1'b0;
      bus.wr_err    <= 1'b0;
      bus.ld_err    <= 1'b0;
      bus.rd_a      <= '0;
      bus.rd_b      <= '0;
      bus.rd_a_len  <= '0;
      bus.rd_b_len  <= '0;
      bus.rd_a_busy <= 1'b0;
      bus.rd_b_busy <= 1'b0;
    end else begin
      bus.ld_ready  <= 1'b1;
      bus.wr_err    <= wr_err_nxt;
      bus.ld_err    <= ld_err_nxt;
      bus.rd_a      <= bus.rd_en_a ? src_a_c      : '0;
      bus.rd_a_len  <= bus.rd_en_a ? src_a_len_c  : '0;
      bus.rd_a_busy <= bus.rd_en_a ? src_a_busy_c : 1'b0;
      bus.rd_b      <= bus.rd_en_b ? src_b_c      : '0;
      bus.rd_b_len  <= bus.rd_en_b ? src_b_len_c  : '0;
      bus.rd_b_busy <= bus.rd_en_b ? src_b_busy_c : 1'b0;
    end
  end
endmodule

// File: tb/tb_vec_reg_file.sv
// Directed bench for vec_reg_file: behavioural model feeds a scoreboard queue, plus fixed-value checks.
module tb_vec_reg_file;
  localparam int unsigned BITS     = 8;
  localparam int unsigned N        = 64;
  localparam int unsigned REGS     = 16;
  localparam int unsigned LEN_BITS = 8;
  localparam int unsigned CW       = N * BITS;

  typedef logic [N-1:0][BITS-1:0] vec_t;
  typedef struct {
    string          tag;
    int             kind;
    logic [CW-1:0]  exp;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  vec_reg_file_if #(.BITS(BITS), .N(N), .REGS(REGS), .LEN_BITS(LEN_BITS)) bus ();

  vec_reg_file #(.BITS(BITS), .N(N), .REGS(REGS), .LEN_BITS(LEN_BITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  vec_t                m_mem [REGS];
  logic [LEN_BITS-1:0] m_len [REGS];
  bit                  m_load;
  bit                  m_drain;
  int                  m_tgt;
  int                  m_cnt;
  exp_t                sb [$];

  task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CW-1:0] obs_of(input int kind);
    case (kind)
      0:       return bus.rd_a;
      1:       return CW'(bus.rd_a_len);
      2:       return CW'(bus.rd_a_busy);
      3:       return bus.rd_b;
      4:       return CW'(bus.rd_b_len);
      5:       return CW'(bus.rd_b_busy);
      6:       return CW'(bus.wr_err);
      default: return CW'(bus.ld_err);
    endcase
  endfunction

  task automatic push(input string tag, input int kind, input logic [CW-1:0] e);
    exp_t x;
    x.tag  = tag;
    x.kind = kind;
    x.exp  = e;
    sb.push_back(x);
  endtask

  task automatic m_reset();
    for (int r = 0; r < int'(REGS); r++) begin
      m_mem[r] = '0;
      m_len[r] = '0;
    end
    m_load  = 1'b0;
    m_drain = 1'b0;
    m_tgt   = 0;
    m_cnt   = 0;
    sb.delete();
  endtask

  task automatic clear_in();
    bus.wr_en    = 1'b0;
    bus.wr_sel   = '0;
    bus.wr_data  = '0;
    bus.wr_mask  = '0;
    bus.wr_len   = '0;
    bus.ld_valid = 1'b0;
    bus.ld_sel   = '0;
    bus.ld_data  = '0;
    bus.ld_last  = 1'b0;
    bus.rd_en_a  = 1'b0;
    bus.rd_en_b  = 1'b0;
    bus.rd_sel_a = '0;
    bus.rd_sel_b = '0;
  endtask

  // Update the model with this cycle's stimulus, queue expectations, clock, then score
  task automatic tick(input string lbl);
    vec_t da, db;
    logic [LEN_BITS-1:0] la, lb;
    logic ba, bb;
    bit rej, ovf;
    int sa, sb2, ws;
    exp_t e;
    sa  = int'(bus.rd_sel_a);
    sb2 = int'(bus.rd_sel_b);
    ws  = int'(bus.wr_sel);
    da = m_mem[sa];  la = m_len[sa];  ba = m_load && (m_tgt == sa);
    db = m_mem[sb2]; lb = m_len[sb2]; bb = m_load && (m_tgt == sb2);
    ovf = 1'b0;
    rej = bus.wr_en && ((m_load && m_tgt == ws) ||
          (bus.ld_valid && !m_load && !m_drain && int'(bus.ld_sel) == ws));
    if (bus.ld_valid) begin
      if (m_drain) begin
        if (bus.ld_last) m_drain = 1'b0;
      end else if (!m_load) begin
        m_tgt = int'(bus.ld_sel);
        m_mem[m_tgt][0] = bus.ld_data;
        m_cnt = 1;
        if (bus.ld_last) m_len[m_tgt] = LEN_BITS'(1);
        else begin
          m_len[m_tgt] = '0;
          m_load = 1'b1;
        end
      end else begin
        m_mem[m_tgt][m_cnt] = bus.ld_data;
        if (bus.ld_last) begin
          m_len[m_tgt] = LEN_BITS'(m_cnt + 1);
          m_load = 1'b0;
        end else if (m_cnt == int'(N) - 1) begin
          m_len[m_tgt] = LEN_BITS'(N);
          m_load  = 1'b0;
          m_drain = 1'b1;
          ovf     = 1'b1;
        end else begin
          m_cnt++;
        end
      end
    end
    if (bus.wr_en && !rej) begin
      for (int i = 0; i < int'(N); i++)
        if (bus.wr_mask[i]) m_mem[ws][i] = bus.wr_data[i];
      m_len[ws] = (int'(bus.wr_len) > int'(N)) ? LEN_BITS'(N) : bus.wr_len;
    end
`ifdef VEC_RF_BYPASS_EN
    da = m_mem[sa];  la = m_len[sa];  ba = m_load && (m_tgt == sa);
    db = m_mem[sb2]; lb = m_len[sb2]; bb = m_load && (m_tgt == sb2);
`endif
    push({lbl, ".rd_a"},      0, bus.rd_en_a ? da : '0);
    push({lbl, ".rd_a_len"},  1, bus.rd_en_a ? CW'(la) : '0);
    push({lbl, ".rd_a_busy"}, 2, bus.rd_en_a ? CW'(ba) : '0);
    push({lbl, ".rd_b"},      3, bus.rd_en_b ? db : '0);
    push({lbl, ".rd_b_len"},  4, bus.rd_en_b ? CW'(lb) : '0);
    push({lbl, ".rd_b_busy"}, 5, bus.rd_en_b ? CW'(bb) : '0);
    push({lbl, ".wr_err"},    6, CW'(rej));
    push({lbl, ".ld_err"},    7, CW'(ovf));
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, obs_of(e.kind), e.exp);
    end
    clear_in();
  endtask

  task automatic read_a(input int r);
    bus.rd_en_a  = 1'b1;
    bus.rd_sel_a = 4'(r);
  endtask

  task automatic read_b(input int r);
    bus.rd_en_b  = 1'b1;
    bus.rd_sel_b = 4'(r);
  endtask

  task automatic bulk(input int r, input vec_t d, input logic [N-1:0] m, input int l);
    bus.wr_en   = 1'b1;
    bus.wr_sel  = 4'(r);
    bus.wr_data = d;
    bus.wr_mask = m;
    bus.wr_len  = LEN_BITS'(l);
  endtask

  task automatic beat(input int r, input int d, input bit last);
    bus.ld_valid = 1'b1;
    bus.ld_sel   = 4'(r);
    bus.ld_data  = BITS'(d);
    bus.ld_last  = last;
  endtask

  vec_t v;
  vec_t ev;

  initial begin
    clear_in();
    m_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.ld_ready", CW'(bus.ld_ready), '0);
    chk("rst.wr_err", CW'(bus.wr_err), '0);
    chk("rst.rd_a", bus.rd_a, '0);
    @(negedge clk);
    rst_n = 1'b1;
    tick("rel");
    chk("rel.ld_ready", CW'(bus.ld_ready), CW'(1));

    // Reset contents on both ports
    read_a(3); read_b(3);
    tick("t1");
    chk("t1.rd_b", bus.rd_b, '0);

    // Masked bulk write with saturating length
    for (int i = 0; i < int'(N); i++) v[i] = BITS'(i);
    bulk(5, v, N'(8'hFF), 200);
    tick("t2wr");
    read_a(5); read_b(5);
    tick("t2rd");
    ev = '0;
    for (int i = 0; i < 8; i++) ev[i] = BITS'(i);
    chk("t2.data", bus.rd_a, ev);
    chk("t2.len", CW'(bus.rd_a_len), CW'(64));

    // Ten-beat stream into reg 2 with a mid-stream read
    for (int k = 0; k < 10; k++) begin
      beat(2, 8'hA0 + k, k == 9);
      if (k == 4) read_a(2);
      tick("t3");
      if (k == 4) begin
        chk("t3.mid_busy", CW'(bus.rd_a_busy), CW'(1));
        chk("t3.mid_len", CW'(bus.rd_a_len), '0);
      end
    end
    read_a(2);
    tick("t3rd");
    ev = '0;
    for (int i = 0; i < 10; i++) ev[i] = BITS'(8'hA0 + i);
    chk("t3.data", bus.rd_a, ev);
    chk("t3.len", CW'(bus.rd_a_len), CW'(10));
    chk("t3.busy", CW'(bus.rd_a_busy), '0);

    // Seventy-beat stream into reg 1: overflow then drain
    for (int k = 0; k < 70; k++) begin
      beat(1, k + 1, k == 69);
      tick("t4");
      if (k == 63) chk("t4.ld_err_pulse", CW'(bus.ld_err), CW'(1));
      if (k == 64) chk("t4.ld_err_clear", CW'(bus.ld_err), '0);
    end
    read_a(1);
    tick("t4rd");
    chk("t4.len", CW'(bus.rd_a_len), CW'(64));
    chk("t4.last_elem", CW'(bus.rd_a[63]), CW'(64));
    beat(1, 8'h33, 1'b1);
    tick("t4new");
    read_a(1);
    tick("t4rd2");
    chk("t4.new_elem0", CW'(bus.rd_a[0]), CW'(8'h33));
    chk("t4.kept_elem1", CW'(bus.rd_a[1]), CW'(2));
    chk("t4.new_len", CW'(bus.rd_a_len), CW'(1));

    // Bulk write collides with the stream; another bulk write proceeds alongside it
    for (int i = 0; i < int'(N); i++) v[i] = 8'hFF;
    beat(2, 8'hB0, 1'b0);
    tick("t5a");
    beat(2, 8'hB1, 1'b0);
    bulk(2, v, '1, 5);
    tick("t5b");
    chk("t5.wr_err", CW'(bus.wr_err), CW'(1));
    for (int i = 0; i < int'(N); i++) v[i] = 8'h77;
    beat(2, 8'hB2, 1'b1);
    bulk(7, v, '1, 3);
    tick("t5c");
    chk("t5.wr_ok", CW'(bus.wr_err), '0);
    read_a(2); read_b(7);
    tick("t5rd");
    chk("t5.reg2_elem1", CW'(bus.rd_a[1]), CW'(8'hB1));
    chk("t5.reg2_elem3", CW'(bus.rd_a[3]), CW'(8'hA3));
    chk("t5.reg2_len", CW'(bus.rd_a_len), CW'(3));
    chk("t5.reg7_elem0", CW'(bus.rd_b[0]), CW'(8'h77));
    chk("t5.reg7_len", CW'(bus.rd_b_len), CW'(3));

    // Same-cycle read and bulk write of reg 4
    for (int i = 0; i < int'(N); i++) v[i] = 8'h11;
    bulk(4, v, '1, 4);
    tick("t6a");
    for (int i = 0; i < int'(N); i++) v[i] = 8'h55;
    bulk(4, v, '1, 6);
    read_a(4);
    tick("t6b");
`ifdef VEC_RF_BYPASS_EN
    chk("t6.same_cycle", CW'(bus.rd_a[0]), CW'(8'h55));
`else
    chk("t6.same_cycle", CW'(bus.rd_a[0]), CW'(8'h11));
`endif
    read_a(4); read_b(4);
    tick("t6c");
    chk("t6.next_cycle", CW'(bus.rd_a[N-1]), CW'(8'h55));
    chk("t6.len", CW'(bus.rd_b_len), CW'(6));

    // Reset in the middle of a stream
    beat(9, 8'hC0, 1'b0);
    tick("t7a");
    beat(9, 8'hC1, 1'b0);
    tick("t7b");
    rst_n = 1'b0;
    #1;
    chk("t7.rst_ready", CW'(bus.ld_ready), '0);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick("t7rel");
    read_a(9); read_b(5);
    tick("t7rd");
    chk("t7.reg5_cleared", CW'(bus.rd_b_len), '0);
    beat(8, 8'h99, 1'b1);
    tick("t7new");
    read_a(8);
    tick("t7rd2");
    chk("t7.first_beat", CW'(bus.rd_a[0]), CW'(8'h99));
    chk("t7.first_len", CW'(bus.rd_a_len), CW'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
